// File: rtl/spi_mst_pkg.sv
// Shared types and widths for the SPI register-access master.
// Holds the FSM state encoding, frame/field widths and the frame builder.
package spi_mst_pkg;

  localparam int FRAME_W   = 16;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int DIV_CNT_W = 8;
  localparam int BIT_CNT_W = 5;
  localparam int GAP_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Reads carry a zero data byte so the slave sees a clean command phase.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              wr,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] data_byte;
    data_byte = wr ? wdata : {DATA_W{1'b0}};
    return {wr, addr, data_byte};
  endfunction

endpackage

// File: rtl/spi_mst_clkdiv.sv
// SCLK half-period divider: while enabled, emits a one-cycle tick on the
// last system cycle of every CLK_DIV-cycle phase; restarts from zero when idle.
module spi_mst_clkdiv
  import spi_mst_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] div_cnt;

  assign o_tick = i_en && (div_cnt == LAST_CNT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en || o_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_mst.sv
// SPI mode-0 master issuing fixed 16-bit register frames (wr, addr, data)
// with a CSB-high gap between frames and a one-cycle response pulse.
module spi_mst
  import spi_mst_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_vld,
  output logic              o_req_rdy,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_vld,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_busy,
  output logic              o_spi_sclk,
  output logic              o_spi_csb,
  output logic              o_spi_mosi,
  input  logic              i_spi_miso
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W - 1);
  localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'(GAP_CYC - 1);

  state_t               state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic                 sclk_q, sclk_d;
  logic                 csb_q, csb_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]    rx_q, rx_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic                 first_high_q, first_high_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 div_en;
  logic                 div_tick;

  spi_mst_clkdiv #(
    .CLK_DIV (CLK_DIV)
  ) u_clkdiv (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (div_en),
    .o_tick  (div_tick)
  );

  assign div_en      = (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign o_req_rdy   = rdy_q;
  assign o_busy      = !rdy_q;
  assign o_spi_sclk  = sclk_q;
  assign o_spi_csb   = csb_q;
  assign o_spi_mosi  = tx_q[FRAME_W-1];
  assign o_rsp_vld   = rsp_vld_q;
  assign o_rsp_rdata = rsp_rdata_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      rdy_q        <= 1'b0;
      sclk_q       <= 1'b0;
      csb_q        <= 1'b1;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      first_high_q <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      sclk_q       <= sclk_d;
      csb_q        <= csb_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      first_high_q <= first_high_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  // MOSI is the MSB of tx, so shifting tx at the end of a high phase is the
  // only place the line can change: the start of the next bit's low phase.
  always_comb begin
    state_d      = state_q;
    sclk_d       = sclk_q;
    csb_d        = csb_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    first_high_d = 1'b0;
    rsp_vld_d    = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req_vld && rdy_q) begin
          state_d   = ST_SHIFT;
          csb_d     = 1'b0;
          sclk_d    = 1'b0;
          tx_d      = build_frame(i_req_wr, i_req_addr, i_req_wdata);
          rx_d      = '0;
          bit_cnt_d = '0;
        end
      end

      ST_SHIFT: begin
        // Bits 7..0 are the ones with bit_cnt in 8..15.
        if (first_high_q && bit_cnt_q[3]) begin
          rx_d = {rx_q[DATA_W-2:0], i_spi_miso};
        end
        if (div_tick) begin
          if (!sclk_q) begin
            sclk_d       = 1'b1;
            first_high_d = 1'b1;
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_d = ST_HOLD;
            end else begin
              tx_d = {tx_q[FRAME_W-2:0], 1'b0};
            end
          end
        end
      end

      ST_HOLD: begin
        if (div_tick) begin
          state_d     = ST_GAP;
          csb_d       = 1'b1;
          rsp_vld_d   = 1'b1;
          rsp_rdata_d = rx_q;
          gap_cnt_d   = '0;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        csb_d   = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // Ready is registered so it stays low through the reset cycles and rises
  // on the first cycle after release, then tracks IDLE exactly.
  always_comb begin
    rdy_d = (state_d == ST_IDLE);
  end

endmodule

// File: tb/tb_spi_mst.sv
// Bench for spi_mst: three instances (CLK_DIV 4/2/255) driven by directed
// steps, with a scoreboard of expected frames and read bytes.
module tb_spi_mst;

  typedef struct {
    int          inst;
    logic [15:0] frame;
    logic [7:0]  miso;
    int          low_len;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n     [3];
  logic       req_vld   [3];
  logic       req_rdy   [3];
  logic       req_wr    [3];
  logic [6:0] req_addr  [3];
  logic [7:0] req_wdata [3];
  logic       rsp_vld   [3];
  logic [7:0] rsp_rdata [3];
  logic       busy      [3];
  logic       spi_sclk  [3];
  logic       spi_csb   [3];
  logic       spi_mosi  [3];
  logic       spi_miso  [3];

  exp_t  sb[$];
  int    acc_t[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;

  int          csb_run   [3];
  int          last_low  [3];
  int          high_run  [3];
  int          last_high [3];
  int          rise_cnt  [3];
  int          rsp_cnt   [3];
  int          bit_idx   [3];
  logic [15:0] mosi_word [3];
  logic [15:0] slave_tx  [3];
  logic        prev_csb  [3];
  logic        prev_sclk [3];

  always #5 clk = ~clk;

  spi_mst #(.CLK_DIV(4), .GAP_CYC(8)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_req_vld(req_vld[0]), .o_req_rdy(req_rdy[0]),
    .i_req_wr(req_wr[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_rsp_vld(rsp_vld[0]), .o_rsp_rdata(rsp_rdata[0]), .o_busy(busy[0]),
    .o_spi_sclk(spi_sclk[0]), .o_spi_csb(spi_csb[0]), .o_spi_mosi(spi_mosi[0]),
    .i_spi_miso(spi_miso[0])
  );

  spi_mst #(.CLK_DIV(2), .GAP_CYC(8)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_req_vld(req_vld[1]), .o_req_rdy(req_rdy[1]),
    .i_req_wr(req_wr[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_vld(rsp_vld[1]), .o_rsp_rdata(rsp_rdata[1]), .o_busy(busy[1]),
    .o_spi_sclk(spi_sclk[1]), .o_spi_csb(spi_csb[1]), .o_spi_mosi(spi_mosi[1]),
    .i_spi_miso(spi_miso[1])
  );

  spi_mst #(.CLK_DIV(255), .GAP_CYC(1)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_req_vld(req_vld[2]), .o_req_rdy(req_rdy[2]),
    .i_req_wr(req_wr[2]), .i_req_addr(req_addr[2]), .i_req_wdata(req_wdata[2]),
    .o_rsp_vld(rsp_vld[2]), .o_rsp_rdata(rsp_rdata[2]), .o_busy(busy[2]),
    .o_spi_sclk(spi_sclk[2]), .o_spi_csb(spi_csb[2]), .o_spi_mosi(spi_mosi[2]),
    .i_spi_miso(spi_miso[2])
  );

  function automatic int div_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 2 : 255);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Drives one request and returns just after the edge that accepts it.
  task automatic applyStimulus(input int g, input logic wr, input logic [6:0] addr,
                               input logic [7:0] wdata, input logic [7:0] miso_byte,
                               input logic keep);
    exp_t e;
    int   n;
    e.inst    = g;
    e.frame   = {wr, addr, (wr ? wdata : 8'h00)};
    e.miso    = miso_byte;
    e.low_len = 33 * div_of(g);
    sb.push_back(e);
    req_wr[g]    = wr;
    req_addr[g]  = addr;
    req_wdata[g] = wdata;
    req_vld[g]   = 1'b1;
    n = 0;
    while (!req_rdy[g] && n < 10000) begin
      step();
      n++;
    end
    if (!req_rdy[g]) checkOutput("rdy_timeout", 32'(req_rdy[g]), 32'd1);
    @(posedge clk);
    acc_t.push_back(int'($time / 10));
    #1;
    if (!keep) req_vld[g] = 1'b0;
  endtask

  task automatic waitRsp(input int g, input int target, input int budget);
    int n;
    n = 0;
    while (rsp_cnt[g] < target && n < budget) begin
      step();
      n++;
    end
    if (rsp_cnt[g] < target) checkOutput("rsp_timeout", 32'(rsp_cnt[g]), 32'(target));
  endtask

  // SPI slave model and frame monitor; MISO changes only on SCLK falls.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (!spi_csb[g]) begin
        if (prev_csb[g]) begin
          last_high[g] = high_run[g];
          csb_run[g]   = 0;
          rise_cnt[g]  = 0;
          mosi_word[g] = 16'h0000;
          bit_idx[g]   = 15;
          slave_tx[g]  = (sb.size() > 0) ? {8'h00, sb[0].miso} : 16'h0000;
          spi_miso[g]  = slave_tx[g][15];
        end
        csb_run[g]++;
        if (spi_sclk[g] && !prev_sclk[g]) begin
          rise_cnt[g]++;
          mosi_word[g] = {mosi_word[g][14:0], spi_mosi[g]};
        end
        if (!spi_sclk[g] && prev_sclk[g]) begin
          bit_idx[g]--;
          if (bit_idx[g] >= 0) spi_miso[g] = slave_tx[g][bit_idx[g][3:0]];
        end
      end else begin
        if (!prev_csb[g]) begin
          last_low[g] = csb_run[g];
          high_run[g] = 0;
        end
        high_run[g]++;
      end
      prev_csb[g]  = spi_csb[g];
      prev_sclk[g] = spi_sclk[g];

      if (rsp_vld[g]) begin
        rsp_cnt[g]++;
        if (sb.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(g), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_inst", 32'(g), 32'(e.inst));
          checkOutput("rsp_rdata", 32'(rsp_rdata[g]), 32'(e.miso));
          checkOutput("mosi_frame", 32'(mosi_word[g]), 32'(e.frame));
          checkOutput("sclk_rises", 32'(rise_cnt[g]), 32'd16);
          checkOutput("csb_low_len", 32'(last_low[g]), 32'(e.low_len));
          checkOutput("csb_high_on_rsp", 32'(spi_csb[g]), 32'd1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst_n[g]     = 1'b0;
      req_vld[g]   = 1'b0;
      req_wr[g]    = 1'b0;
      req_addr[g]  = 7'h00;
      req_wdata[g] = 8'h00;
    end
    repeat (3) step();

    $display("[TB] reset state");
    checkOutput("rst_rdy", 32'(req_rdy[0]), 32'd0);
    checkOutput("rst_busy", 32'(busy[0]), 32'd1);
    checkOutput("rst_csb", 32'(spi_csb[0]), 32'd1);
    checkOutput("rst_sclk", 32'(spi_sclk[0]), 32'd0);
    checkOutput("rst_mosi", 32'(spi_mosi[0]), 32'd0);
    checkOutput("rst_rsp_vld", 32'(rsp_vld[0]), 32'd0);
    checkOutput("rst_rdata", 32'(rsp_rdata[0]), 32'd0);
    for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
    step();
    for (int g = 0; g < 3; g++) checkOutput("rel_rdy", 32'(req_rdy[g]), 32'd1);
    checkOutput("rel_busy", 32'(busy[0]), 32'd0);

    $display("[TB] write 0x12 <- 0xA5");
    applyStimulus(0, 1'b1, 7'h12, 8'hA5, 8'h5A, 1'b0);
    checkOutput("wr_csb_t1", 32'(spi_csb[0]), 32'd0);
    checkOutput("wr_mosi_t1", 32'(spi_mosi[0]), 32'd1);
    checkOutput("wr_busy", 32'(busy[0]), 32'd1);
    waitRsp(0, 1, 400);
    step();
    checkOutput("rsp_pulse_width", 32'(rsp_vld[0]), 32'd0);

    $display("[TB] read 0x05");
    applyStimulus(0, 1'b0, 7'h05, 8'hFF, 8'h3C, 1'b0);
    waitRsp(0, 2, 400);

    $display("[TB] requests while busy");
    applyStimulus(0, 1'b1, 7'h33, 8'hC3, 8'h81, 1'b0);
    repeat (20) step();
    checkOutput("busy_shift", 32'(busy[0]), 32'd1);
    req_vld[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 7'h7F; req_wdata[0] = 8'h00;
    step(); step();
    req_vld[0] = 1'b0;
    waitRsp(0, 3, 400);
    req_vld[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 7'h11; req_wdata[0] = 8'h99;
    step();
    checkOutput("busy_gap", 32'(busy[0]), 32'd1);
    step();
    req_vld[0] = 1'b0;
    repeat (30) step();
    checkOutput("busy_rsp_count", 32'(rsp_cnt[0]), 32'd3);
    checkOutput("busy_idle_rdy", 32'(req_rdy[0]), 32'd1);
    checkOutput("busy_csb_idle", 32'(spi_csb[0]), 32'd1);
    checkOutput("rdata_hold", 32'(rsp_rdata[0]), 32'h81);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 1'b1, 7'h2A, 8'h55, 8'hF0, 1'b0);
    for (int n = 0; n < 1000 && rise_cnt[0] < 7; n++) step();
    repeat (8) step();
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_csb", 32'(spi_csb[0]), 32'd1);
    checkOutput("abort_sclk", 32'(spi_sclk[0]), 32'd0);
    checkOutput("abort_rdy", 32'(req_rdy[0]), 32'd0);
    sb.delete(0);
    step();
    rst_n[0] = 1'b1;
    step();
    checkOutput("abort_rel_rdy", 32'(req_rdy[0]), 32'd1);
    repeat (200) step();
    checkOutput("abort_no_rsp", 32'(rsp_cnt[0]), 32'd3);

    $display("[TB] back-to-back, CLK_DIV=2");
    acc_t.delete();
    applyStimulus(1, 1'b1, 7'h01, 8'h11, 8'hA1, 1'b1);
    applyStimulus(1, 1'b0, 7'h02, 8'h22, 8'hB2, 1'b1);
    step();
    checkOutput("b2b_gap1", 32'(last_high[1]), 32'd9);
    applyStimulus(1, 1'b1, 7'h03, 8'h33, 8'hC4, 1'b0);
    step();
    checkOutput("b2b_gap2", 32'(last_high[1]), 32'd9);
    checkOutput("b2b_space1", 32'(acc_t[1] - acc_t[0]), 32'd75);
    checkOutput("b2b_space2", 32'(acc_t[2] - acc_t[1]), 32'd75);
    waitRsp(1, 3, 400);
    repeat (20) step();
    checkOutput("b2b_rsp_count", 32'(rsp_cnt[1]), 32'd3);

    $display("[TB] boundary, CLK_DIV=255 GAP_CYC=1");
    applyStimulus(2, 1'b1, 7'h7F, 8'hFF, 8'h69, 1'b0);
    waitRsp(2, 1, 9000);
    step();
    checkOutput("bnd_rdy_after_gap", 32'(req_rdy[2]), 32'd1);
    repeat (20) step();
    checkOutput("bnd_rsp_count", 32'(rsp_cnt[2]), 32'd1);
    checkOutput("bnd_csb_idle", 32'(spi_csb[2]), 32'd1);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
